// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: diff = a - b, one bit per clock, LSB first.
// Define SERIAL_SUB_OVF_EN to add the signed-overflow output ovf.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] d_sh_q, d_sh_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic [CW-1:0]    count_q, count_d;
  logic             br_q, br_d;
  logic             borrow_out_q, borrow_out_d;
  logic             bit_d, br_next, last_bit;
`ifdef SERIAL_SUB_OVF_EN
  logic             a_msb_q, a_msb_d;
  logic             b_msb_q, b_msb_d;
  logic             ovf_q, ovf_d;
`endif

  // Full-subtractor cell working on the current LSB of the shifting operands.
  assign bit_d    = a_sh_q[0] ^ b_sh_q[0] ^ br_q;
  assign br_next  = (~a_sh_q[0] & b_sh_q[0]) | (~(a_sh_q[0] ^ b_sh_q[0]) & br_q);
  assign last_bit = (count_q == CW'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      a_sh_q       <= '0;
      b_sh_q       <= '0;
      d_sh_q       <= '0;
      diff_q       <= '0;
      count_q      <= '0;
      br_q         <= 1'b0;
      borrow_out_q <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      a_msb_q      <= 1'b0;
      b_msb_q      <= 1'b0;
      ovf_q        <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      a_sh_q       <= a_sh_d;
      b_sh_q       <= b_sh_d;
      d_sh_q       <= d_sh_d;
      diff_q       <= diff_d;
      count_q      <= count_d;
      br_q         <= br_d;
      borrow_out_q <= borrow_out_d;
`ifdef SERIAL_SUB_OVF_EN
      a_msb_q      <= a_msb_d;
      b_msb_q      <= b_msb_d;
      ovf_q        <= ovf_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (last_bit) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Result bits enter at the MSB of d_sh so after WIDTH shifts the first bit sits at bit 0.
  always_comb begin
    a_sh_d       = a_sh_q;
    b_sh_d       = b_sh_q;
    d_sh_d       = d_sh_q;
    diff_d       = diff_q;
    count_d      = count_q;
    br_d         = br_q;
    borrow_out_d = borrow_out_q;
`ifdef SERIAL_SUB_OVF_EN
    a_msb_d      = a_msb_q;
    b_msb_d      = b_msb_q;
    ovf_d        = ovf_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          a_sh_d  = a;
          b_sh_d  = b;
          d_sh_d  = '0;
          br_d    = 1'b0;
          count_d = '0;
`ifdef SERIAL_SUB_OVF_EN
          a_msb_d = a[WIDTH-1];
          b_msb_d = b[WIDTH-1];
`endif
        end
      end
      RUN: begin
        a_sh_d = a_sh_q >> 1;
        b_sh_d = b_sh_q >> 1;
        d_sh_d = {bit_d, d_sh_q[WIDTH-1:1]};
        br_d   = br_next;
        if (last_bit) begin
          diff_d       = {bit_d, d_sh_q[WIDTH-1:1]};
          borrow_out_d = br_next;
`ifdef SERIAL_SUB_OVF_EN
          ovf_d        = (a_msb_q != b_msb_q) && (bit_d != a_msb_q);
`endif
        end else begin
          count_d = count_q + CW'(1);
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    busy       = (state_q != IDLE);
    done       = (state_q == DONE);
    diff       = diff_q;
    borrow_out = borrow_out_q;
`ifdef SERIAL_SUB_OVF_EN
    ovf        = ovf_q;
`endif
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: directed operations with a scoreboard
// of reference results popped whenever done pulses.
module tb_serial_subtractor;

  localparam int WIDTH = 8;

  typedef struct {
    logic [WIDTH-1:0] diff;
    logic             borrow;
    logic             ovf;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow_out;
`ifdef SERIAL_SUB_OVF_EN
  logic             ovf;
`endif

  int   tests = 0;
  int   fails = 0;
  int   done_count = 0;
  exp_t sb[$];
  exp_t last_exp;

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .a          (a),
    .b          (b),
    .busy       (busy),
    .done       (done),
    .diff       (diff),
    .borrow_out (borrow_out)
`ifdef SERIAL_SUB_OVF_EN
    ,
    .ovf        (ovf)
`endif
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model: widened unsigned subtract for diff/borrow, integer range test for ovf.
  task automatic applyStimulus(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv);
    exp_t           e;
    logic [WIDTH:0] wide;
    int             sr;
    @(negedge clk);
    a     = av;
    b     = bv;
    start = 1'b1;
    wide     = {1'b0, av} - {1'b0, bv};
    e.diff   = wide[WIDTH-1:0];
    e.borrow = wide[WIDTH];
    sr       = int'($signed(av)) - int'($signed(bv));
    e.ovf    = (sr > (2 ** (WIDTH - 1)) - 1) || (sr < -(2 ** (WIDTH - 1)));
    sb.push_back(e);
    last_exp = e;
  endtask

  // Runs one operation; optionally pokes start during RUN and during DONE.
  task automatic runOp(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv, input bit poke);
    int edges;
    int dc0;
    dc0 = done_count;
    applyStimulus(av, bv);
    @(negedge clk);
    start = 1'b0;
    edges = 1;
    checkOutput("busy_after_start", 32'(busy), 32'd1);
    while (done !== 1'b1 && edges < 4 * WIDTH) begin
      if (poke && edges == 3) begin
        start = 1'b1;
        a     = 8'h10;
        b     = 8'h01;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      edges++;
    end
    checkOutput("latency_edges", 32'(edges), 32'(WIDTH + 1));
    checkOutput("busy_in_done", 32'(busy), 32'd1);
    if (poke) begin
      start = 1'b1;
      a     = 8'h10;
      b     = 8'h01;
    end
    @(negedge clk);
    start = 1'b0;
    checkOutput("done_one_cycle", 32'(done), 32'd0);
    checkOutput("busy_after_done", 32'(busy), 32'd0);
    checkOutput("done_pulses", 32'(done_count - dc0), 32'd1);
  endtask

  // Scoreboard consumer: every done pulse must match the oldest pending expectation.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      exp_t e;
      done_count++;
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $error("[TB] FAIL unexpected_done: observed done=1 expected done=0");
      end else begin
        e = sb.pop_front();
        checkOutput("diff", 32'(diff), 32'(e.diff));
        checkOutput("borrow_out", 32'(borrow_out), 32'(e.borrow));
`ifdef SERIAL_SUB_OVF_EN
        checkOutput("ovf", 32'(ovf), 32'(e.ovf));
`endif
      end
    end
  end

  initial begin
    int dc0;
    rst   = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    repeat (2) @(negedge clk);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_done", 32'(done), 32'd0);
    checkOutput("reset_diff", 32'(diff), 32'd0);
    checkOutput("reset_borrow", 32'(borrow_out), 32'd0);
`ifdef SERIAL_SUB_OVF_EN
    checkOutput("reset_ovf", 32'(ovf), 32'd0);
`endif
    rst = 1'b0;

    runOp(8'h05, 8'h03, 1'b0);
    runOp(8'h03, 8'h05, 1'b0);
    runOp(8'h00, 8'h00, 1'b0);
    runOp(8'hFF, 8'h01, 1'b0);
    runOp(8'h00, 8'hFF, 1'b0);

    runOp(8'h20, 8'h07, 1'b1);
    repeat (WIDTH + 2) @(negedge clk);
    checkOutput("diff_hold", 32'(diff), 32'(last_exp.diff));
    checkOutput("borrow_hold", 32'(borrow_out), 32'(last_exp.borrow));

    // Abort an operation with rst on the 4th RUN edge.
    dc0 = done_count;
    @(negedge clk);
    a     = 8'h40;
    b     = 8'h01;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("abort_busy", 32'(busy), 32'd0);
    checkOutput("abort_done", 32'(done), 32'd0);
    checkOutput("abort_diff", 32'(diff), 32'd0);
    checkOutput("abort_borrow", 32'(borrow_out), 32'd0);
    repeat (WIDTH + 2) @(negedge clk);
    checkOutput("abort_no_done", 32'(done_count - dc0), 32'd0);

    runOp(8'h40, 8'h01, 1'b0);
    runOp(8'h80, 8'h01, 1'b0);
    runOp(8'h05, 8'h03, 1'b0);

    checkOutput("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
